// File: rtl/wb_select_stage.sv
// -----------------------------------------------------------------------------
// wb_select_stage
//
// Write-back source selection stage. Each accepted instruction picks one of
// NSRC write-data sources and produces a single-cycle register-file write.
// Slice MEM_IDX is special: its data comes from the memory read port, which
// may arrive late. If it is not valid on the accept cycle, the stage stalls
// (in_ready low) until mem_valid arrives or TMO wait cycles elapse. A timeout
// drops the write and pulses mem_err.
//
// Parameters
//   WIDTH    data width
//   NSRC     number of write-data sources (>= 2)
//   SELW     select width, $clog2(NSRC)
//   AW       register-address width
//   MEM_IDX  index of the late-arriving memory source
//   TMO      max WAIT_MEM cycles before giving up (1..255)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   issue-side instruction valid
//   in_ready   out  stage can accept an instruction (high exactly in IDLE)
//   sel        in   write-data source select (out-of-range selects slice 0)
//   src_data   in   packed sources, source k in [k*WIDTH +: WIDTH]
//   rd_in      in   destination register
//   wen_in     in   instruction writes a register
//   mem_data   in   memory read data, replaces slice MEM_IDX
//   mem_valid  in   mem_data valid this cycle
//   wb_en      out  register-file write enable (one-cycle pulse)
//   wb_addr    out  register-file write address (holds last value)
//   wb_data    out  register-file write data (holds last value)
//   mem_err    out  one-cycle pulse when the memory wait timed out
//   busy_cnt   out  saturating count of cycles spent stalled in WAIT_MEM
// -----------------------------------------------------------------------------
module wb_select_stage #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 4,
    parameter int SELW    = 2,
    parameter int AW      = 5,
    parameter int MEM_IDX = 1,
    parameter int TMO     = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [AW-1:0]         rd_in,
    input  logic                  wen_in,
    input  logic [WIDTH-1:0]      mem_data,
    input  logic                  mem_valid,
    output logic                  wb_en,
    output logic [AW-1:0]         wb_addr,
    output logic [WIDTH-1:0]      wb_data,
    output logic                  mem_err,
    output logic [15:0]           busy_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t            state_q,   state_d;
    logic [7:0]        wait_q,    wait_d;
    logic [AW-1:0]     rd_q,      rd_d;
    logic              wen_q,     wen_d;
    logic              wb_en_q,   wb_en_d;
    logic [AW-1:0]     wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]  wb_data_q, wb_data_d;
    logic              mem_err_q, mem_err_d;
    logic [15:0]       busy_q,    busy_d;

    // Effective source index: an out-of-range select falls back to slice 0,
    // and the memory-source decision is made on that effective index.
    int                sel_idx;
    int                eff_idx;
    logic [WIDTH-1:0]  sel_slice;
    logic              is_mem;
    logic [7:0]        wait_inc;

    always_comb begin
        sel_idx   = 32'(sel);
        eff_idx   = (sel_idx < NSRC) ? sel_idx : 0;
        is_mem    = (eff_idx == MEM_IDX);
        sel_slice = src_data[0 +: WIDTH];
        for (int k = 0; k < NSRC; k++) begin
            if (eff_idx == k) begin
                sel_slice = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        mem_err_d = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_en_d   = wen_in && (rd_in != '0);
                        wb_addr_d = rd_in;
                        wb_data_d = sel_slice;
                    end else if (mem_valid) begin
                        wb_en_d   = wen_in && (rd_in != '0);
                        wb_addr_d = rd_in;
                        wb_data_d = mem_data;
                    end else begin
                        // Memory data not here yet: remember the destination
                        // and stall until it shows up or we give up.
                        rd_d    = rd_in;
                        wen_d   = wen_in;
                        wait_d  = 8'd0;
                        state_d = WAIT_MEM;
                    end
                end
            end

            WAIT_MEM: begin
                busy_d = (busy_q == 16'hFFFF) ? busy_q : busy_q + 16'd1;
                // mem_valid is tested first so a late arrival on the final
                // wait cycle still completes the write instead of timing out.
                if (mem_valid) begin
                    wb_en_d   = wen_q && (rd_q != '0);
                    wb_addr_d = rd_q;
                    wb_data_d = mem_data;
                    wait_d    = 8'd0;
                    state_d   = IDLE;
                end else if (wait_inc == 8'(TMO)) begin
                    mem_err_d = 1'b1;
                    wait_d    = 8'd0;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= 8'd0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            mem_err_q <= 1'b0;
            busy_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            mem_err_q <= mem_err_d;
            busy_q    <= busy_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign mem_err  = mem_err_q;
    assign busy_cnt = busy_q;

endmodule
